// File: rtl/score_update_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// score_update_arbiter_pkg
//   Constants shared by the score update arbiter and its adder.
//   - SCORE_W    : width of a score and of a points value. The shared
//                  ripple-carry adder is built for this width.
//   - SCORE_MAX  : saturation value, 2**SCORE_W - 1.
//   - ST_*       : FSM state encodings.
//   - player_onehot() : converts a player index into a one-hot pair.
// -----------------------------------------------------------------------------
package score_update_arbiter_pkg;

    localparam int              SCORE_W   = 6;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 6'd63;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    function automatic logic [1:0] player_onehot(input logic player);
        return player ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/score_update_arbiter_rca.sv
// -----------------------------------------------------------------------------
// score_update_arbiter_rca
//   Ripple-carry adder of SCORE_W bits. Each bit is a plain full adder; the
//   carry ripples from bit 0 upward. The carry out of the top bit is the
//   overflow the arbiter uses to decide saturation.
//
// Ports
//   a     in   SCORE_W   operand A
//   b     in   SCORE_W   operand B
//   cin   in   1         carry into bit 0
//   sum   out  SCORE_W   a + b + cin, truncated
//   cout  out  1         carry out of bit SCORE_W-1
// -----------------------------------------------------------------------------
module score_update_arbiter_rca
    import score_update_arbiter_pkg::*;
(
    input  logic [SCORE_W-1:0] a,
    input  logic [SCORE_W-1:0] b,
    input  logic               cin,
    output logic [SCORE_W-1:0] sum,
    output logic               cout
);

    logic [SCORE_W-1:0] carry;

    genvar i;
    generate
        for (i = 0; i < SCORE_W; i++) begin : g_bit
            logic c_in_bit;
            if (i == 0) begin : g_lsb
                assign c_in_bit = cin;
            end else begin : g_upper
                assign c_in_bit = carry[i-1];
            end
            assign sum[i]   = a[i] ^ b[i] ^ c_in_bit;
            assign carry[i] = (a[i] & b[i]) | (c_in_bit & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry[SCORE_W-1];

endmodule

// File: rtl/score_update_arbiter.sv
// -----------------------------------------------------------------------------
// score_update_arbiter
//   Shares one SCORE_W-bit ripple-carry adder between two player hit-scoring
//   units. Score-increment requests are serialised with round-robin
//   arbitration and a req/ack handshake; each running score saturates at
//   SCORE_MAX and sets a sticky saturation flag.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; on any req, grant and latch operands
//   ADD   | adder settles on op_a/op_b; result written at the exiting edge
//   ACK   | ack[grant] high for one cycle; round-robin pointer advances
//
// Ports
//   clk     in   1        system clock, rising edge
//   reset   in   1        synchronous active-high reset
//   clear   in   1        synchronous clear of both scores (new song)
//   req     in   2        req[p]: player p requests an add, held until ack[p]
//   pts0    in   6        points for player 0, stable while req[0] is high
//   pts1    in   6        points for player 1, stable while req[1] is high
//   ack     out  2        one-cycle pulse: player p's add has completed
//   score0  out  6        player 0 running score
//   score1  out  6        player 1 running score
//   sat     out  2        sticky: player p's score has saturated
//   busy    out  1        high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module score_update_arbiter
    import score_update_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [1:0]         req,
    input  logic [SCORE_W-1:0] pts0,
    input  logic [SCORE_W-1:0] pts1,
    output logic [1:0]         ack,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [1:0]         sat,
    output logic               busy
);

    logic [1:0]         state;
    logic               grant;
    logic               grant_next;
    logic               rr_ptr;
    logic [SCORE_W-1:0] op_a;
    logic [SCORE_W-1:0] op_b;
    logic [SCORE_W-1:0] add_sum;
    logic               add_cout;

    score_update_arbiter_rca u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // A lone request wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        grant_next = req[1];
        if (req == 2'b11) begin
            grant_next = rr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            grant  <= 1'b0;
            rr_ptr <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            score0 <= '0;
            score1 <= '0;
            sat    <= 2'b00;
        end else if (clear) begin
            // rr_ptr is deliberately left alone so fairness carries over songs.
            state  <= ST_IDLE;
            score0 <= '0;
            score1 <= '0;
            sat    <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant <= grant_next;
                        op_a  <= grant_next ? score1 : score0;
                        op_b  <= grant_next ? pts1   : pts0;
                        state <= ST_ADD;
                    end
                end

                ST_ADD: begin
                    // Carry out of the top bit means the true sum exceeds
                    // SCORE_MAX, so clamp and flag.
                    if (grant) begin
                        score1 <= add_cout ? SCORE_MAX : add_sum;
                    end else begin
                        score0 <= add_cout ? SCORE_MAX : add_sum;
                    end
                    if (add_cout) begin
                        sat[grant] <= 1'b1;
                    end
                    state <= ST_ACK;
                end

                ST_ACK: begin
                    rr_ptr <= ~grant;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ack is decoded from the state register, so it is exactly one cycle
    // wide and can only ever name the single granted player.
    assign ack  = (state == ST_ACK) ? player_onehot(grant) : 2'b00;
    assign busy = (state != ST_IDLE);

endmodule
